// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle between the register-file read stage
// (master) and the sequential ALU (slave).
//   START   - request, accepted on a rising clock edge while READY=1
//   A, B    - unsigned operands (B is the shift amount for SHL/SHR)
//   SEL     - 4-bit opcode
//   READY   - ALU can accept START this cycle
//   DONE    - one-cycle pulse: ALU_OUT/FLAG hold a new result
//   ALU_OUT - registered result
//   FLAG    - registered flags {borrow, overflow, carry, zero}
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             START;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       SEL;
  logic             READY;
  logic             DONE;
  logic [WIDTH-1:0] ALU_OUT;
  logic [3:0]       FLAG;

  modport master (output START, A, B, SEL, input READY, DONE, ALU_OUT, FLAG);
  modport slave  (input START, A, B, SEL, output READY, DONE, ALU_OUT, FLAG);
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU with a start/ready/done handshake.
// Single-cycle ops register their result at the accepting edge. MUL runs a
// shift-add engine (multiplier LSB first) and DIV/REM a restoring divider
// (quotient MSB first); both spend exactly WIDTH cycles in CALC.
// Ports:
//   CLK   - rising-edge clock
//   RST_N - asynchronous active-low reset; aborts any operation in flight
//   bus   - alu_seq_if slave modport (START/A/B/SEL in, READY/DONE/ALU_OUT/FLAG out)
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic      CLK,
  input  logic      RST_N,
  alu_seq_if.slave  bus
);

  localparam int               CW    = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] W_MAX = WIDTH'(WIDTH);

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_MUL  = 4'h2, OP_DIV  = 4'h3,
    OP_SHL  = 4'h4, OP_SHR  = 4'h5, OP_AND  = 4'h6, OP_OR   = 4'h7,
    OP_XOR  = 4'h8, OP_XNOR = 4'h9, OP_NAND = 4'hA, OP_NOR  = 4'hB,
    OP_REM  = 4'hC, OP_RS_D = 4'hD, OP_RS_E = 4'hE, OP_RS_F = 4'hF
  } op_e;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;
  typedef enum logic [1:0] {M_MUL, M_DIV, M_REM} mode_e;

  op_e              op;
  state_e           state, state_n;
  mode_e            mode;
  logic             ready, done, accept, go_calc;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opd;        // multiplicand (MUL) or divisor (DIV/REM)
  logic [WIDTH-1:0] hi, lo;     // MUL: product {hi,lo}; DIV: remainder hi, quotient lo
  logic             lt_q;       // A<B captured at accept, for the DIV/REM borrow flag
  logic [WIDTH-1:0] hi_n, lo_n;
  logic [WIDTH:0]   mul_sum, rem_sh, diff, sh_wide;
  logic [WIDTH-1:0] s_res, c_res, alu_out_q;
  logic [3:0]       s_flag, c_flag, flag_q;
  logic             s_zero;

  assign op     = op_e'(bus.SEL);
  assign accept = bus.START && ready;

  // Single-cycle result, computed from the live inputs at the accepting edge.
  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    s_res   = '0;
    s_flag  = '0;
    s_zero  = 1'b1;
    sh_wide = '0;
    go_calc = 1'b0;
    case (op)
      OP_ADD: {s_flag[1], s_res} = {1'b0, bus.A} + {1'b0, bus.B};
      OP_SUB: begin
        s_res     = bus.A - bus.B;
        s_flag[3] = (bus.A < bus.B);
      end
      OP_MUL: go_calc = 1'b1;
      OP_DIV, OP_REM: begin
        if (bus.B == '0) begin
          s_res  = '1;
          s_flag = 4'h4;
          s_zero = 1'b0;
        end else begin
          go_calc = 1'b1;
        end
      end
      // The extra bit beside A catches the last bit shifted out.
      OP_SHL: begin
        if (bus.B <= W_MAX) begin
          sh_wide   = {1'b0, bus.A} << bus.B;
          s_res     = sh_wide[WIDTH-1:0];
          s_flag[1] = sh_wide[WIDTH];
        end
      end
      OP_SHR: begin
        if (bus.B <= W_MAX) begin
          sh_wide   = {bus.A, 1'b0} >> bus.B;
          s_res     = sh_wide[WIDTH:1];
          s_flag[1] = sh_wide[0];
        end
      end
      OP_AND:  s_res = bus.A & bus.B;
      OP_OR:   s_res = bus.A | bus.B;
      OP_XOR:  s_res = bus.A ^ bus.B;
      OP_XNOR: s_res = ~(bus.A ^ bus.B);
      OP_NAND: s_res = ~(bus.A & bus.B);
      OP_NOR:  s_res = ~(bus.A | bus.B);
      default: s_zero = 1'b0;          // reserved opcodes report no flags
    endcase
    if (s_zero) s_flag[0] = (s_res == '0);
  end

  // One iteration of the multiply / restoring-divide engine, plus the result
  // that the final iteration would produce.
  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opd} : '0);
    rem_sh  = {hi, lo[WIDTH-1]};
    diff    = rem_sh - {1'b0, opd};
    if (mode == M_MUL) begin
      hi_n = mul_sum[WIDTH:1];
      lo_n = {mul_sum[0], lo[WIDTH-1:1]};
    end else begin
      // A negative trial difference (top bit set) restores the shifted remainder.
      hi_n = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
      lo_n = {lo[WIDTH-2:0], ~diff[WIDTH]};
    end
    c_res  = hi_n;
    c_flag = '0;
    case (mode)
      M_MUL: begin
        c_res     = lo_n;
        c_flag[2] = (hi_n != '0);
      end
      M_DIV: begin
        c_res     = lo_n;
        c_flag[3] = lt_q;
      end
      default: c_flag[3] = lt_q;
    endcase
    c_flag[0] = (c_res == '0);
  end

  // NOTE: sequential state is always written with non-blocking assignments so
  // every register samples pre-edge values regardless of process order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    ready   = 1'b1;
    done    = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        done = (state == S_DONE);
        if (bus.START) state_n = go_calc ? S_CALC : S_DONE;
        else           state_n = S_IDLE;
      end
      S_CALC: begin
        ready = 1'b0;
        if (cnt == '0) state_n = S_DONE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // NOTE: the engine registers are reset alongside the outputs so an aborted
  // operation leaves no partial product or remainder behind.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mode      <= M_MUL;
      cnt       <= '0;
      opd       <= '0;
      hi        <= '0;
      lo        <= '0;
      lt_q      <= 1'b0;
      alu_out_q <= '0;
      flag_q    <= '0;
    end else if (accept) begin
      mode <= (op == OP_MUL) ? M_MUL : ((op == OP_DIV) ? M_DIV : M_REM);
      cnt  <= CW'(WIDTH - 1);
      opd  <= (op == OP_MUL) ? bus.A : bus.B;
      hi   <= '0;
      lo   <= (op == OP_MUL) ? bus.B : bus.A;
      lt_q <= (bus.A < bus.B);
      if (!go_calc) begin
        alu_out_q <= s_res;
        flag_q    <= s_flag;
      end
    end else if (state == S_CALC) begin
      hi  <= hi_n;
      lo  <= lo_n;
      cnt <= cnt - 1'b1;
      if (cnt == '0) begin
        alu_out_q <= c_res;
        flag_q    <= c_flag;
      end
    end
  end

  assign bus.READY   = ready;
  assign bus.DONE    = done;
  assign bus.ALU_OUT = alu_out_q;
  assign bus.FLAG    = flag_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq at WIDTH=8 and WIDTH=16.
// Stimulus pushes the expected result, flags and completion cycle into a
// per-instance queue; a negedge monitor pops and compares whenever DONE rises.
module tb_alu_seq;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   last_due = 0;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flag;
    int          due;
    bit          multi;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];

  alu_seq_if #(.WIDTH(8))  if8 ();
  alu_seq_if #(.WIDTH(16)) if16 ();

  alu_seq #(.WIDTH(8))  dut8  (.CLK(clk), .RST_N(rst_n), .bus(if8));
  alu_seq #(.WIDTH(16)) dut16 (.CLK(clk), .RST_N(rst_n), .bus(if16));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: opcode rules evaluated with plain 64-bit arithmetic.
  function automatic void model(input int w, input logic [3:0] sel,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output logic [3:0] flag,
                                output int lat);
    longint unsigned m, av, bv, full, wl;
    bit zf;
    wl   = longint'(w);
    m    = (64'd1 << w) - 64'd1;
    av   = longint'(a) & m;
    bv   = longint'(b) & m;
    full = 0;
    res  = '0;
    flag = '0;
    lat  = 1;
    zf   = 1'b1;
    case (sel)
      4'h0: begin full = av + bv; res = 32'(full & m); flag[1] = (full > m); end
      4'h1: begin res = 32'((av - bv) & m); flag[3] = (av < bv); end
      4'h2: begin
        full = av * bv; res = 32'(full & m);
        flag[2] = ((full >> w) != 0); lat = w + 1;
      end
      4'h3, 4'hC: begin
        if (bv == 0) begin
          res = 32'(m); flag = 4'h4; zf = 1'b0;
        end else begin
          res = (sel == 4'h3) ? 32'(av / bv) : 32'(av % bv);
          flag[3] = (av < bv); lat = w + 1;
        end
      end
      4'h4: if (bv <= wl) begin
        full = av << bv; res = 32'(full & m); flag[1] = (((full >> w) & 1) != 0);
      end
      4'h5: begin
        if (bv == 0) res = 32'(av);
        else if (bv <= wl) begin
          res = 32'(av >> bv); flag[1] = (((av >> (bv - 1)) & 1) != 0);
        end
      end
      4'h6: res = 32'(av & bv);
      4'h7: res = 32'(av | bv);
      4'h8: res = 32'(av ^ bv);
      4'h9: res = 32'(~(av ^ bv) & m);
      4'hA: res = 32'(~(av & bv) & m);
      4'hB: res = 32'(~(av | bv) & m);
      default: zf = 1'b0;
    endcase
    if (zf) flag[0] = (res == 0);
  endfunction

  // Issue one request on instance idx (0: WIDTH=8, 1: WIDTH=16). When use_exp
  // is set the caller's constants replace the model's result and flags.
  task automatic issue(input int idx, input logic [3:0] sel,
                       input logic [31:0] a, input logic [31:0] b,
                       input bit use_exp = 1'b0, input logic [31:0] xres = 0,
                       input logic [3:0] xflag = 0);
    exp_t e;
    int   guard;
    int   lat;
    guard = 0;
    @(negedge clk);
    while (!(idx != 0 ? if16.READY : if8.READY)) begin
      guard++;
      if (guard > 64) begin
        check("ready_timeout", 32'(0), 32'(1));
        return;
      end
      @(negedge clk);
    end
    if (idx != 0) begin
      if16.START = 1'b1; if16.A = a[15:0]; if16.B = b[15:0]; if16.SEL = sel;
    end else begin
      if8.START = 1'b1; if8.A = a[7:0]; if8.B = b[7:0]; if8.SEL = sel;
    end
    @(posedge clk);
    model(idx != 0 ? 16 : 8, sel, a, b, e.res, e.flag, lat);
    if (use_exp) begin
      e.res  = xres;
      e.flag = xflag;
    end
    e.due    = cyc + lat;
    e.multi  = (lat > 1);
    last_due = e.due;
    if (idx != 0) q16.push_back(e);
    else          q8.push_back(e);
    #1;
    // Scramble the inputs so a design that fails to latch them is caught.
    if (idx != 0) begin
      if16.START = 1'b0; if16.A = 16'($urandom); if16.B = 16'($urandom); if16.SEL = 4'($urandom);
    end else begin
      if8.START = 1'b0; if8.A = 8'($urandom); if8.B = 8'($urandom); if8.SEL = 4'($urandom);
    end
  endtask

  task automatic mon(input int idx, input logic done, input logic ready,
                     input logic [31:0] out, input logic [3:0] flag);
    string tag;
    int    n;
    exp_t  f;
    tag = (idx != 0) ? "w16" : "w8";
    n   = (idx != 0) ? q16.size() : q8.size();
    if (n > 0) f = (idx != 0) ? q16[0] : q8[0];
    if (n > 0 && f.multi && cyc < f.due) check({tag, " ready_in_calc"}, 32'(ready), 32'(0));
    if (done) begin
      if (n == 0) begin
        check({tag, " spurious_done"}, 32'(1), 32'(0));
      end else begin
        check({tag, " done_cycle"}, 32'(cyc), 32'(f.due));
        check({tag, " alu_out"}, out, f.res);
        check({tag, " flag"}, 32'(flag), 32'(f.flag));
        check({tag, " ready_in_done"}, 32'(ready), 32'(1));
        if (idx != 0) void'(q16.pop_front());
        else          void'(q8.pop_front());
      end
    end else if (n > 0 && cyc >= f.due) begin
      check({tag, " missing_done"}, 32'(0), 32'(1));
      if (idx != 0) void'(q16.pop_front());
      else          void'(q8.pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, if8.DONE, if8.READY, 32'(if8.ALU_OUT), if8.FLAG);
      mon(1, if16.DONE, if16.READY, 32'(if16.ALU_OUT), if16.FLAG);
    end
  end

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (q8.size() != 0 || q16.size() != 0) begin
      @(negedge clk);
      guard++;
      if (guard > 200) begin
        check("drain_timeout", 32'(q8.size() + q16.size()), 32'(0));
        q8.delete();
        q16.delete();
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  sel;
    logic [31:0] a, b;
    int          idx;

    rst_n = 1'b0;
    if8.START  = 1'b0; if8.A  = '0; if8.B  = '0; if8.SEL  = '0;
    if16.START = 1'b0; if16.A = '0; if16.B = '0; if16.SEL = '0;
    repeat (2) @(negedge clk);
    check("w8 reset ready", 32'(if8.READY), 32'(1));
    check("w8 reset done", 32'(if8.DONE), 32'(0));
    check("w8 reset alu_out", 32'(if8.ALU_OUT), 32'(0));
    check("w8 reset flag", 32'(if8.FLAG), 32'(0));
    check("w16 reset ready", 32'(if16.READY), 32'(1));
    check("w16 reset alu_out", 32'(if16.ALU_OUT), 32'(0));
    #2 rst_n = 1'b1;

    // ADD at WIDTH=8, the second leaving a non-zero result before the abort.
    issue(0, 4'h0, 200, 56, 1'b1, 0, 4'b0011);
    issue(0, 4'h0, 200, 100, 1'b1, 44, 4'b0010);

    // Reset three cycles into a MUL: immediate idle state, no DONE later.
    issue(0, 4'h2, 16, 16);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    q8.delete();
    #1;
    check("abort ready", 32'(if8.READY), 32'(1));
    check("abort alu_out", 32'(if8.ALU_OUT), 32'(0));
    check("abort flag", 32'(if8.FLAG), 32'(0));
    check("abort done", 32'(if8.DONE), 32'(0));
    @(negedge clk);
    #2 rst_n = 1'b1;
    while (cyc < last_due) @(negedge clk);
    check("abort no_done", 32'(if8.DONE), 32'(0));

    // Directed WIDTH=8 cases; consecutive issues run back-to-back.
    issue(0, 4'h1, 9, 10, 1'b1, 255, 4'b1000);
    issue(0, 4'h1, 10, 10, 1'b1, 0, 4'b0001);
    issue(0, 4'h2, 10, 7, 1'b1, 70, 4'b0000);
    issue(0, 4'h2, 16, 16, 1'b1, 0, 4'b0101);
    issue(0, 4'h3, 135, 5, 1'b1, 27, 4'b0000);
    issue(0, 4'hC, 135, 7, 1'b1, 2, 4'b0000);
    issue(0, 4'h3, 11, 0, 1'b1, 255, 4'b0100);
    issue(0, 4'h4, 129, 1, 1'b1, 2, 4'b0010);
    issue(0, 4'h5, 24, 4, 1'b1, 1, 4'b0010);
    issue(0, 4'h4, 12, 11, 1'b1, 0, 4'b0001);
    issue(0, 4'hA, 255, 255, 1'b1, 0, 4'b0001);
    issue(0, 4'hE, 77, 33, 1'b1, 0, 4'b0000);

    // WIDTH=16 repeats.
    issue(1, 4'h2, 300, 300, 1'b1, 24464, 4'b0100);
    issue(1, 4'h0, 40000, 30000, 1'b1, 4464, 4'b0010);
    wait_idle();

    // Randomised traffic on both instances against the reference model.
    for (int i = 0; i < 120; i++) begin
      idx = (i % 3 == 2) ? 1 : 0;
      sel = 4'($urandom);
      a   = $urandom;
      b   = $urandom;
      if ($urandom_range(0, 2) == 0) b = $urandom_range(0, 20);
      if ($urandom_range(0, 7) == 0) a = 0;
      repeat ($urandom_range(0, 1)) @(negedge clk);
      issue(idx, sel, a, b);
    end
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
